// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// bit-counter width helper.
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter spans 0..width-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register for the serializer: captures a word while the
// shifter is busy and hands it over at the end of the current word.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             ready
);

  // load only happens while empty and take only while full, so they never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (take) begin
      full <= 1'b0;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the four-ones detector. Words arrive over
// valid/ready and leave one bit per clock; a one-word hold buffer keeps the stream gapless.
import bit_serializer_pkg::*;

module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             ser_last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Handshake: a word moves only at a rising edge where load_valid && load_ready;
  // load_ready reflects the registered hold-buffer state and never load_valid.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             transfer;
  logic             end_of_word;
  logic             hold_load;
  logic             hold_take;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign transfer    = load_valid && load_ready;
  assign end_of_word = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign hold_load   = transfer && (state == ST_SHIFT) && !end_of_word;
  assign hold_take   = end_of_word && hold_full;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .take  (hold_take),
    .din   (load_data),
    .dout  (hold_data),
    .full  (hold_full),
    .ready (load_ready)
  );

  // shreg holds the bits not yet shown; ser_out already carries the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      ser_out    <= 1'b0;
      ser_active <= 1'b0;
      ser_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            state      <= ST_SHIFT;
            cnt        <= '0;
            shreg      <= shift_once(load_data);
            ser_out    <= first_bit(load_data);
            ser_active <= 1'b1;
            ser_last   <= 1'b0;
          end else begin
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            ser_last   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (end_of_word) begin
            cnt      <= '0;
            ser_last <= 1'b0;
            if (hold_full) begin
              shreg      <= shift_once(hold_data);
              ser_out    <= first_bit(hold_data);
              ser_active <= 1'b1;
            end else if (transfer) begin
              shreg      <= shift_once(load_data);
              ser_out    <= first_bit(load_data);
              ser_active <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              shreg      <= '0;
              ser_out    <= 1'b0;
              ser_active <= 1'b0;
            end
          end else begin
            cnt      <= cnt + CW'(1);
            shreg    <= shift_once(shreg);
            ser_out  <= first_bit(shreg);
            ser_last <= ((cnt + CW'(1)) == CNT_LAST);
          end
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          shreg      <= '0;
          ser_out    <= 1'b0;
          ser_active <= 1'b0;
          ser_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the four-consecutive-ones sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on ser_out, which connects to the detector's serial input. A one-entry holding buffer lets consecutive words stream with no idle gap. When idle, ser_out drives 0, which returns the downstream detector to its zero-count state.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
load_valid  in  1  source presents a word on load_data
load_data  in  WIDTH  word to serialize
load_ready  out  1  block can accept a word this cycle
ser_out  out  1  serial bit stream to the detector
ser_active  out  1  ser_out carries a valid word bit this cycle
ser_last  out  1  ser_out carries the final bit of a word this cycle

Behaviour:
- Interface is fixed: reset rst, asynchronous, active-high; clock clk.
- Reset values: ser_out=0, ser_active=0, ser_last=0, shift register=0, bit counter=0, hold buffer empty, state=IDLE. Because load_ready = !hold_full, it reads 1 from reset. Reset asserted mid-word takes effect immediately (async): the in-flight word and any held word are discarded.
- Transfer occurs only at a rising edge with load_valid && load_ready. load_data is ignored at every other edge.
- load_ready is combinational from the registered hold_full flag only. It never depends on load_valid.
- States: IDLE and SHIFT. The bit counter spans 0..WIDTH-1, with width $clog2(WIDTH).
- IDLE: a transfer at edge k loads the word directly into the shift register. The first bit appears on ser_out after edge k (zero added latency beyond the register), with ser_active=1, counter=0, and the state moves to SHIFT. With no transfer, the block stays in IDLE with ser_out=0 and ser_active=0.
- SHIFT: each edge advances one bit. Bit order is MSB-first when MSB_FIRST=1, otherwise LSB-first. ser_last=1 exactly while counter==WIDTH-1.
- A transfer during SHIFT goes into the hold buffer (hold_full<=1).
- End of word (the edge that ends the ser_last cycle), in priority order:
  a) If hold_full: load the hold buffer into the shift register, set hold_full<=0, counter=0, stay in SHIFT. load_ready was 0 this cycle, so no new transfer can occur.
  b) Else, if a transfer occurs this edge: bypass the hold buffer, load the shift register directly, counter=0, stay in SHIFT.
  c) Else: go to IDLE with ser_out=0 and ser_active=0.
- Both (a) and (b) produce gapless output: ser_active stays 1 across the word boundary.
- Only one word is ever buffered. load_ready=0 from the edge hold fills until the edge it drains.
- ser_out, ser_active and ser_last are all registered outputs with no combinational path from inputs.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_SHIFT=1) and a counter-width helper based on $clog2(WIDTH).
- One natural sub-module, ser_hold_buf: a WIDTH-bit register with a full flag, load/take strobes and the ready output.
- Top level keeps the FSM, counter and shift register.

Test Plan:
1. Reset, then transfer 8'hF0 once (MSB_FIRST=1) -> ser_out = 1,1,1,1,0,0,0,0 on 8 consecutive cycles. ser_active is high for those 8 cycles and ser_last is high on the 8th only. Afterwards ser_out=0, ser_active=0, and load_ready=1 throughout.
2. Hold load_valid high with 8'hA5 then 8'h3C -> second word is accepted one cycle later, and load_ready=0 for the next 7 cycles. Output is 16 contiguous bits 10100101 00111100 with no ser_active drop. ser_last pulses on cycles 8 and 16.
3. Offer 8'h81 exactly in the ser_last cycle of a prior word with hold empty (bypass) -> the next cycle shows bit 1 of 8'h81 with no gap and load_ready stays 1.
4. MSB_FIRST=0, transfer 8'h01 -> ser_out = 1 followed by seven 0s.
5. Assert rst after 3 bits of 8'hFF while the hold buffer holds 8'hFF -> ser_out=0, ser_active=0 and load_ready=1 immediately without a clock edge. After release, no residual bits are emitted.
6. Connect the downstream four-ones detector and send 8'h1E (00011110) -> the detector's out is high for exactly 1 cycle. Then send 8'hFF, 8'hFF back-to-back -> out stays high for 13 consecutive cycles.
